// File: rtl/hex_line_tx.sv
// Queues result words in a small FIFO and prints each one on the UART as
// NDIG uppercase hex digits followed by CR LF, using the rs232out we/busy handshake.
module hex_line_tx #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_word,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               tx_data,
    output logic                     tx_we,
    input  logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     idle
);
    localparam int NDIG = WIDTH / 4;
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int CW   = $clog2(NDIG + 1);

    typedef enum logic [1:0] {S_IDLE, S_DIGIT, S_CR, S_LF} state_t;

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             nonempty_q;
    logic             push, pop, consumed;

    state_t           state, state_n;
    logic [WIDTH-1:0] shifter, shifter_n, shifted;
    logic [CW-1:0]    cnt, cnt_n;
    logic [7:0]       data_n;
    logic             we_n;

    assign in_ready = (level != LW'(DEPTH));
    assign push     = in_valid && in_ready;
    // nonempty_q lags level by one edge, so a freshly written word sits one
    // cycle in the FIFO before the line engine may pop it.
    assign pop      = (state == S_IDLE) && nonempty_q && (level != '0);
    assign consumed = tx_we && !tx_busy;
    assign shifted  = shifter << 4;
    assign idle     = (level == '0) && (state == S_IDLE);

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= in_word;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            nonempty_q <= 1'b0;
        end else begin
            nonempty_q <= (level != '0);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            shifter <= '0;
            cnt     <= '0;
            tx_data <= 8'h00;
            tx_we   <= 1'b0;
        end else begin
            state   <= state_n;
            shifter <= shifter_n;
            cnt     <= cnt_n;
            tx_data <= data_n;
            tx_we   <= we_n;
        end
    end

    always_comb begin
        state_n   = state;
        shifter_n = shifter;
        cnt_n     = cnt;
        data_n    = tx_data;
        we_n      = tx_we;
        case (state)
            S_IDLE: if (pop) begin
                shifter_n = mem[rd_ptr];
                cnt_n     = CW'(NDIG);
                data_n    = hex(mem[rd_ptr][WIDTH-1 -: 4]);
                we_n      = 1'b1;
                state_n   = S_DIGIT;
            end
            S_DIGIT: if (consumed) begin
                shifter_n = shifted;
                cnt_n     = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    data_n  = 8'h0D;
                    state_n = S_CR;
                end else begin
                    data_n  = hex(shifted[WIDTH-1 -: 4]);
                end
            end
            S_CR: if (consumed) begin
                data_n  = 8'h0A;
                state_n = S_LF;
            end
            S_LF: if (consumed) begin
                we_n    = 1'b0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule
